// File: rtl/adder_pkg.sv
// adder_pkg: shared elaboration-time helpers for the pipelined ripple-carry adder.
//   chunk_width() - bits added by each pipeline stage
//   config_ok()   - legality of a WIDTH/STAGES pair (WIDTH >= 1, STAGES >= 1,
//                   WIDTH divisible by STAGES)
package adder_pkg;

    function automatic int chunk_width(input int width, input int stages);
        // Guard the division so an illegal STAGES of 0 reaches config_ok()
        // instead of failing inside the width arithmetic.
        return (stages > 0) ? (width / stages) : 1;
    endfunction

    function automatic bit config_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit structural full adder cell.
//   a, b, cin - addend bits and carry-in
//   sum, cout - sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/rca_chunk.sv
// rca_chunk: combinational N-bit ripple of full_adder cells.
//   a, b - N-bit operands
//   cin  - carry into bit 0
//   sum  - N-bit sum
//   cout - carry out of bit N-1
//   cmsb - carry into bit N-1 (used for signed overflow)
module rca_chunk #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    // carry[k] is the carry into bit k; carry[N] leaves the chunk.
    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar k = 0; k < N; k++) begin : g_bit
        full_adder u_fa (
            .a    (a[k]),
            .b    (b[k]),
            .cin  (carry[k]),
            .sum  (sum[k]),
            .cout (carry[k+1])
        );
    end

    assign cout = carry[N];
    assign cmsb = carry[N-1];

endmodule

// File: rtl/pipelined_rca.sv
// pipelined_rca: WIDTH-bit adder whose carry chain is cut into STAGES equal
// chunks, one register boundary per chunk, with valid/ready flow control.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake
//   in_a, in_b, in_cin   - operands and carry-in
//   out_valid / out_ready- result handshake
//   out_sum              - (a + b + cin) mod 2^WIDTH
//   out_cout, out_ovf    - unsigned carry-out, signed overflow
//
// Stage i adds bits [i*CHUNK +: CHUNK]. Its register keeps the low sum bits
// finished so far, the operand bits not yet added (already shifted so the
// next chunk sits at bit 0), the chunk carry and a valid bit. Every stage
// advances together on a single global enable, so bubbles are preserved.
module pipelined_rca
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!config_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $fatal(1, "pipelined_rca: WIDTH must be a positive multiple of STAGES");
    end

    // The whole pipe moves whenever the output slot is empty or being drained.
    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int LO     = i * CHUNK;       // first bit added here
        localparam int DONE   = LO + CHUNK;      // sum bits complete after this stage
        localparam int REM_IN = WIDTH - LO;      // operand bits still to add, incl. this chunk

        logic [REM_IN-1:0] a_src;
        logic [REM_IN-1:0] b_src;
        logic              c_src;
        logic              v_src;
        logic [CHUNK-1:0]  s_c;
        logic              c_out;
        logic              c_msb;
        logic [DONE-1:0]   sum_d;

        logic [DONE-1:0]   sum_q;
        logic              c_q;
        logic              v_q;

        if (i == 0) begin : g_head
            assign a_src = in_a;
            assign b_src = in_b;
            assign c_src = in_cin;
            // Loading only when adv (== in_ready) makes this in_valid & in_ready.
            assign v_src = in_valid;
            assign sum_d = s_c;
        end else begin : g_body
            assign a_src = g_stage[i-1].g_rem.a_q;
            assign b_src = g_stage[i-1].g_rem.b_q;
            assign c_src = g_stage[i-1].c_q;
            assign v_src = g_stage[i-1].v_q;
            assign sum_d = {s_c, g_stage[i-1].sum_q};
        end

        rca_chunk #(.N(CHUNK)) u_chunk (
            .a    (a_src[CHUNK-1:0]),
            .b    (b_src[CHUNK-1:0]),
            .cin  (c_src),
            .sum  (s_c),
            .cout (c_out),
            .cmsb (c_msb)
        );

        // NOTE: clocked state uses non-blocking assignments so every stage
        // samples its predecessor's pre-edge value and the pipe shifts by one.
        // NOTE: data registers are reset too, not only valid bits, so the
        // outputs read as zero (never X) before the first result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q   <= v_src;
                c_q   <= c_out;
                sum_q <= sum_d;
            end
        end

        // Operand bits above this chunk travel on to the following stages.
        if (i < STAGES - 1) begin : g_rem
            logic [REM_IN-CHUNK-1:0] a_q;
            logic [REM_IN-CHUNK-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_src[REM_IN-1:CHUNK];
                    b_q <= b_src[REM_IN-1:CHUNK];
                end
            end
        end

        // Only the last stage sees the word's MSB, so only it keeps the
        // carry into that bit for the overflow flag.
        if (i == STAGES - 1) begin : g_tail
            logic m_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_q <= 1'b0;
                end else if (adv) begin
                    m_q <= c_msb;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign out_sum   = g_stage[STAGES-1].sum_q;
    assign out_cout  = g_stage[STAGES-1].c_q;
    assign out_ovf   = g_stage[STAGES-1].g_tail.m_q ^ g_stage[STAGES-1].c_q;

endmodule
